ref_gen_sweep: RTL and testbench
================================

// Module: ref_gen_sweep
// PURPOSE
//  Programmable square-wave reference for the DRSSTC phase/feedback path. Successor to the fixed-rate
//  generator: adds run/stop control with clean low-level stop, and glitch-free per-period updates.
//  Adds an optional linear frequency sweep START->END by STEP per period, with optional loop.
//  Configured over the shared data/addr/en write bus; sits between the config decoder and the driver logic.
// PARAMETERS
//  CLK_MHZ        100  system clock, MHz
//  FREQ_MID_KHZ   200  output frequency at mid-scale value, kHz
//  GEN_PARAMETER  255  max tuning value; W = $clog2(GEN_PARAMETER+1) (8)
//  ADDR_MAX       7    max bus address (sets addr width)
//  ADDR_BASE      4    address of reg 0; regs at ADDR_BASE+0..3
//  RESET_VALUE    79   reset value of START/END/cur_val (~250 kHz)
//  RUN_AT_RESET   1    reset value of CTRL.run (1 = free-runs like legacy generator)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   async active-low reset
//  data        in   W   write data
//  addr        in   `wire(ADDR_MAX)  write address
//  en          in   1   write strobe
//  out         out  1   reference square wave
//  sync        out  1   1-cycle pulse, asserted in the cycle out goes 0->1
//  cur_val     out  W   tuning value of the period in progress
//  busy        out  1   state != IDLE
//  sweep_done  out  1   sweep_en && cur_val==END && state==RUN
// BEHAVIOUR
//  Reset (async, rst_n=0): out=0, sync=0, busy=0, sweep_done=0, cnt=0, state=IDLE,
//   START=END=cur_val=RESET_VALUE, STEP=0, CTRL={loop0,sweep0,run=RUN_AT_RESET}.
//  Regs (write when en && addr==ADDR_BASE+k, visible next cycle; other addrs ignored):
//   k0 START, k1 END, k2 STEP, k3 CTRL[0]=run [1]=sweep_en [2]=loop.
//  CNT_MIN = `div(500*CLK_MHZ, FREQ_MID_KHZ) - (GEN_PARAMETER>>1) (=123 default), elaboration-time.
//  Half-period = CNT_MIN+cur_val cycles; both halves of a period use the same cur_val.
//  cnt width holds CNT_MIN+GEN_PARAMETER-1.
//  FSM IDLE/RUN/STOPPING:
//   IDLE: out=0, cnt=0. run=1 -> out<=1, sync<=1, cur_val<=START, cnt<=CNT_MIN+START-1, ->RUN.
//   RUN: cnt!=0 -> cnt-1. cnt==0 && out==1 -> out<=0, cnt<=CNT_MIN+cur_val-1.
//    cnt==0 && out==0 -> out<=1, sync<=1, cur_val<=nxt, cnt<=CNT_MIN+nxt-1.
//    run==0 -> STOPPING (same cycle's toggle still obeys RUN rules).
//   STOPPING: counts as RUN; at cnt==0: out==1 -> out<=0, ->IDLE; out==0 -> no toggle, ->IDLE.
//    run=1 again before then -> RUN, no glitch.
//  nxt (rising toggle only): sweep_en=0 -> START. sweep_en=1: cur==END -> (loop ? START : END);
//   END>cur -> min(cur+STEP, END); END<cur -> max(cur-STEP, END).
//   Arithmetic in W+1 bits; saturate at END, never wrap. STEP=0 holds value.
//  Mid-period writes never change the current period; they take effect at the next rising toggle.
//  Write to CTRL in the same cycle as a toggle: toggle uses old CTRL.
//  sync is registered, exactly 1 cycle; out never shows a pulse shorter than CNT_MIN cycles.
// STRUCTURE
//  ref_gen_pkg: state enum, register offset localparams, cnt_min function. Include defines.sv for
//   `wire/`reg/`div.
//  Sub-module ref_gen_regs: register bank + CTRL decode. Counter/FSM/sweep stay in ref_gen_sweep.
// TESTING (defaults, CNT_MIN=123)
//  Release reset -> out rises next cycle; high 202, low 202; sync every 404 cycles.
//  Write START=0 mid-high -> current period 202/202, next 123/123, cur_val=0 at that rising edge.
//  START=0 END=10 STEP=4 sweep_en -> half-periods 123,127,131,133,133..; sweep_done from 4th period.
//   With loop=1, 5th period returns to 123.
//  START=200 END=190 STEP=7 -> half-periods 323,316,313,313. START=250 END=255 STEP=15 -> 373,378, no wrap.
//  run cleared mid-high -> out falls on schedule, busy drops, no further edges.
//   Cleared mid-low -> stays low, IDLE at cnt==0. Re-set -> out rises next cycle.
//  rst_n pulsed mid-high -> out=0 asynchronously; registers at reset values; restart as test 1.

Source files
------------

// File: rtl/ref_gen_pkg.sv
// Shared types and elaboration-time helpers for the swept square-wave reference generator.
package ref_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // Register offsets relative to ADDR_BASE
  localparam int unsigned REG_START = 0;
  localparam int unsigned REG_END   = 1;
  localparam int unsigned REG_STEP  = 2;
  localparam int unsigned REG_CTRL  = 3;

  // CTRL bit positions
  localparam int unsigned CTRL_RUN   = 0;
  localparam int unsigned CTRL_SWEEP = 1;
  localparam int unsigned CTRL_LOOP  = 2;

  // Shortest half-period, chosen so that mid-scale tuning lands on FREQ_MID_KHZ.
  function automatic int unsigned cnt_min(input int unsigned clk_mhz,
                                          input int unsigned freq_mid_khz,
                                          input int unsigned gen_parameter);
    return (500 * clk_mhz) / freq_mid_khz - (gen_parameter >> 1);
  endfunction

endpackage

// File: rtl/ref_gen_regs.sv
// Configuration register bank (START/END/STEP/CTRL) on the shared write bus.
module ref_gen_regs
  import ref_gen_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned AW           = 3,
  parameter int unsigned ADDR_BASE    = 4,
  parameter int unsigned RESET_VALUE  = 79,
  parameter int unsigned RUN_AT_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  data,
  input  logic [AW-1:0] addr,
  input  logic          en,
  output logic [W-1:0]  start_val,
  output logic [W-1:0]  end_val,
  output logic [W-1:0]  step_val,
  output logic          run,
  output logic          sweep_en,
  output logic          loop_en
);

  localparam logic [AW-1:0] A_START    = AW'(ADDR_BASE + REG_START);
  localparam logic [AW-1:0] A_END      = AW'(ADDR_BASE + REG_END);
  localparam logic [AW-1:0] A_STEP     = AW'(ADDR_BASE + REG_STEP);
  localparam logic [AW-1:0] A_CTRL     = AW'(ADDR_BASE + REG_CTRL);
  localparam logic [2:0]    CTRL_RESET = {2'b00, RUN_AT_RESET != 0};

  logic [W-1:0] start_q, start_d;
  logic [W-1:0] end_q, end_d;
  logic [W-1:0] step_q, step_d;
  logic [2:0]   ctrl_q, ctrl_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    step_d  = step_q;
    ctrl_d  = ctrl_q;
    if (en) begin
      if (addr == A_START) start_d = data;
      if (addr == A_END)   end_d   = data;
      if (addr == A_STEP)  step_d  = data;
      if (addr == A_CTRL)  ctrl_d  = data[2:0];
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= W'(RESET_VALUE);
      end_q   <= W'(RESET_VALUE);
      step_q  <= '0;
      ctrl_q  <= CTRL_RESET;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
      step_q  <= step_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign start_val = start_q;
  assign end_val   = end_q;
  assign step_val  = step_q;
  assign run       = ctrl_q[CTRL_RUN];
  assign sweep_en  = ctrl_q[CTRL_SWEEP];
  assign loop_en   = ctrl_q[CTRL_LOOP];

endmodule

// File: rtl/ref_gen_sweep.sv
// Programmable square-wave reference with run/stop control and optional linear frequency sweep.
module ref_gen_sweep
  import ref_gen_pkg::*;
#(
  parameter  int unsigned CLK_MHZ       = 100,
  parameter  int unsigned FREQ_MID_KHZ  = 200,
  parameter  int unsigned GEN_PARAMETER = 255,
  parameter  int unsigned ADDR_MAX      = 7,
  parameter  int unsigned ADDR_BASE     = 4,
  parameter  int unsigned RESET_VALUE   = 79,
  parameter  int unsigned RUN_AT_RESET  = 1,
  localparam int unsigned W             = $clog2(GEN_PARAMETER + 1),
  localparam int unsigned AW            = $clog2(ADDR_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  data,
  input  logic [AW-1:0] addr,
  input  logic          en,
  output logic          out,
  output logic          sync,
  output logic [W-1:0]  cur_val,
  output logic          busy,
  output logic          sweep_done
);

  localparam int unsigned CNT_MIN = cnt_min(CLK_MHZ, FREQ_MID_KHZ, GEN_PARAMETER);
  localparam int unsigned CW      = $clog2(CNT_MIN + GEN_PARAMETER);

  logic [W-1:0] start_val, end_val, step_val;
  logic         run, sweep_en, loop_en;

  ref_gen_regs #(
    .W           (W),
    .AW          (AW),
    .ADDR_BASE   (ADDR_BASE),
    .RESET_VALUE (RESET_VALUE),
    .RUN_AT_RESET(RUN_AT_RESET)
  ) u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .addr     (addr),
    .en       (en),
    .start_val(start_val),
    .end_val  (end_val),
    .step_val (step_val),
    .run      (run),
    .sweep_en (sweep_en),
    .loop_en  (loop_en)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          sync_q, sync_d;
  logic [W-1:0]  cur_val_q, cur_val_d;
  logic [W-1:0]  nxt_val;
  logic [W:0]    cur_x, end_x, step_x, sum_x, dif_x;
  logic          keep_running;

  function automatic logic [CW-1:0] reload(input logic [W-1:0] v);
    return CW'(CNT_MIN - 1) + CW'(v);
  endfunction

  // Sweep step in W+1 bits: carry/borrow shows up in the top bit and clamps to END instead of wrapping.
  always_comb begin
    cur_x   = {1'b0, cur_val_q};
    end_x   = {1'b0, end_val};
    step_x  = {1'b0, step_val};
    sum_x   = cur_x + step_x;
    dif_x   = cur_x - step_x;
    nxt_val = start_val;
    if (sweep_en) begin
      if (cur_val_q == end_val) begin
        nxt_val = loop_en ? start_val : end_val;
      end else if (end_val > cur_val_q) begin
        nxt_val = (sum_x > end_x) ? end_val : sum_x[W-1:0];
      end else begin
        nxt_val = (dif_x[W] || dif_x < end_x) ? end_val : dif_x[W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    sync_d       = 1'b0;
    cur_val_d    = cur_val_q;
    keep_running = (state_q == ST_RUN) || run;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        out_d = 1'b0;
        if (run) begin
          out_d     = 1'b1;
          sync_d    = 1'b1;
          cur_val_d = start_val;
          cnt_d     = reload(start_val);
          state_d   = ST_RUN;
        end
      end
      ST_RUN, ST_STOPPING: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
          state_d = run ? ST_RUN : ST_STOPPING;
        end else if (keep_running) begin
          // A toggle in the cycle run drops still follows the normal schedule.
          if (out_q) begin
            out_d = 1'b0;
            cnt_d = reload(cur_val_q);
          end else begin
            out_d     = 1'b1;
            sync_d    = 1'b1;
            cur_val_d = nxt_val;
            cnt_d     = reload(nxt_val);
          end
          state_d = run ? ST_RUN : ST_STOPPING;
        end else begin
          out_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      sync_q    <= 1'b0;
      cur_val_q <= W'(RESET_VALUE);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      sync_q    <= sync_d;
      cur_val_q <= cur_val_d;
    end
  end

  assign out        = out_q;
  assign sync       = sync_q;
  assign cur_val    = cur_val_q;
  assign busy       = (state_q != ST_IDLE);
  assign sweep_done = sweep_en && (cur_val_q == end_val) && (state_q == ST_RUN);

endmodule

// File: tb/tb_ref_gen_sweep.sv
// Bench for ref_gen_sweep: half-period scoreboard, sweep vector table and run/stop/reset sequences.
module tb_ref_gen_sweep;

  localparam int CNT_MIN = 123;
  localparam int A_START = 4;
  localparam int A_END   = 5;
  localparam int A_STEP  = 6;
  localparam int A_CTRL  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = '0;
  logic [2:0] addr = '0;
  logic       en = 1'b0;
  logic       out, sync, busy, sweep_done;
  logic [7:0] cur_val;

  ref_gen_sweep dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .addr      (addr),
    .en        (en),
    .out       (out),
    .sync      (sync),
    .cur_val   (cur_val),
    .busy      (busy),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit lvl;
    int len;
    int val;
    bit chk_val;
    bit done;
  } half_t;

  half_t sb[$];

  function automatic void push_half(bit lvl, int len, int val, bit chk_val, bit done);
    half_t h;
    h.lvl = lvl; h.len = len; h.val = val; h.chk_val = chk_val; h.done = done;
    sb.push_back(h);
  endfunction

  function automatic void expect_period(int val, bit done);
    push_half(1'b1, CNT_MIN + val, val, 1'b1, done);
    push_half(1'b0, CNT_MIN + val, val, 1'b0, 1'b0);
  endfunction

  // Called at the first sample of a half (or init samples into it); returns at the first sample of the next.
  task automatic measure_next(input int init);
    half_t e;
    int    len;
    logic  lvl;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e   = sb.pop_front();
    lvl = out;
    check("half_level", lvl, e.lvl);
    if (e.lvl && init == 0) begin
      check("sync_at_rise", sync, 1);
      if (e.chk_val) begin
        check("cur_val_at_rise", cur_val, e.val);
        check("sweep_done", sweep_done, e.done);
      end
    end
    len = init;
    do begin
      @(negedge clk);
      len++;
    end while (out === lvl && len < 1000);
    check("half_len", len, e.len);
  endtask

  task automatic wr(input int a, input int d);
    addr = a[2:0];
    data = d[7:0];
    en   = 1'b1;
    @(negedge clk);
    en   = 1'b0;
  endtask

  task automatic wait_out_high();
    int n = 0;
    while (out !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_high", out, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_idle", busy, 0);
  endtask

  // sync must be high exactly in the sample where out has just risen.
  logic prev_out = 1'b0;
  always @(negedge clk) begin
    if (rst_n && (sync || (out && !prev_out)))
      check("sync_vs_rise", sync, out && !prev_out);
    prev_out = out;
  end

  typedef struct {
    int start_v;
    int end_v;
    int step_v;
    bit sweep;
    bit loop;
    int vals[5];
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int glitch;
    vec_t v;

    vecs[0] = '{79,  79,  0,  1'b0, 1'b0, '{79, 79, 79, 79, 79}};
    vecs[1] = '{0,   10,  4,  1'b1, 1'b0, '{0, 4, 8, 10, 10}};
    vecs[2] = '{0,   10,  4,  1'b1, 1'b1, '{0, 4, 8, 10, 0}};
    vecs[3] = '{200, 190, 7,  1'b1, 1'b0, '{200, 193, 190, 190, 190}};
    vecs[4] = '{250, 255, 15, 1'b1, 1'b0, '{250, 255, 255, 255, 255}};
    vecs[5] = '{0,   255, 0,  1'b1, 1'b0, '{0, 0, 0, 0, 0}};
    vecs[6] = '{5,   0,   9,  1'b1, 1'b1, '{5, 0, 5, 0, 5}};
    vecs[7] = '{255, 255, 0,  1'b0, 1'b0, '{255, 255, 255, 255, 255}};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_sync", sync, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_cur_val", cur_val, 79);
    rst_n = 1'b1;
    @(negedge clk);
    check("rise_after_reset", out, 1);

    // Free-run at reset value, then START=0 written mid-high
    expect_period(79, 1'b0);
    expect_period(79, 1'b0);
    expect_period(0, 1'b0);
    measure_next(0);
    measure_next(0);
    check("sync_period2", sync, 1);
    repeat (50) @(negedge clk);
    wr(A_START, 0);
    check("still_high_after_write", out, 1);
    measure_next(51);
    measure_next(0);
    measure_next(0);
    measure_next(0);

    // run cleared mid-high: falls on schedule, then idle with no edges
    repeat (20) @(negedge clk);
    wr(A_CTRL, 0);
    push_half(1'b1, CNT_MIN, 0, 1'b0, 1'b0);
    measure_next(21);
    check("stop_high_out", out, 0);
    check("stop_high_busy", busy, 0);
    glitch = 0;
    repeat (300) begin
      @(negedge clk);
      if (out !== 1'b0) glitch++;
    end
    check("no_edges_after_stop", glitch, 0);

    // Re-enable: rises the cycle after run becomes visible
    wr(A_CTRL, 1);
    check("restart_not_yet", out, 0);
    @(negedge clk);
    check("restart_rise", out, 1);

    // run cleared mid-low: stays low, idle when the low half ends
    push_half(1'b1, CNT_MIN, 0, 1'b1, 1'b0);
    measure_next(0);
    repeat (20) @(negedge clk);
    wr(A_CTRL, 0);
    len = 21;
    glitch = 0;
    while (busy === 1'b1 && len < 1000) begin
      @(negedge clk);
      len++;
      if (out !== 1'b0) glitch++;
    end
    check("stop_low_idle_at", len, CNT_MIN);
    check("stop_low_no_glitch", glitch, 0);

    // run dropped and re-raised within a high half: no disturbance
    wr(A_CTRL, 1);
    wait_out_high();
    repeat (10) @(negedge clk);
    wr(A_CTRL, 0);
    repeat (10) @(negedge clk);
    wr(A_CTRL, 1);
    push_half(1'b1, CNT_MIN, 0, 1'b0, 1'b0);
    push_half(1'b0, CNT_MIN, 0, 1'b0, 1'b0);
    expect_period(0, 1'b0);
    measure_next(22);
    measure_next(0);
    measure_next(0);
    measure_next(0);

    // Async reset mid-high restores registers; restart at reset value
    repeat (30) @(negedge clk);
    check("high_before_reset", out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_cur_val", cur_val, 79);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rise_after_reset2", out, 1);
    expect_period(79, 1'b0);
    measure_next(0);
    measure_next(0);
    wr(A_CTRL, 0);
    wait_idle();

    // Table-driven sweep vectors, each started from idle
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      wr(A_START, v.start_v);
      wr(A_END, v.end_v);
      wr(A_STEP, v.step_v);
      wr(A_CTRL, (v.loop ? 4 : 0) + (v.sweep ? 2 : 0) + 1);
      wait_out_high();
      for (int p = 0; p < 5; p++)
        expect_period(v.vals[p], v.sweep && (v.vals[p] == v.end_v));
      for (int h = 0; h < 10; h++)
        measure_next(0);
      wr(A_CTRL, (v.loop ? 4 : 0) + (v.sweep ? 2 : 0));
      wait_idle();
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
